// File: rtl/mult4x4_pkg.sv
// rtl/mult4x4_pkg.sv - shared widths, state encoding and constants for the 4x4 multiplier tile
package mult4x4_pkg;

    localparam int OP_W   = 4;
    localparam int PROD_W = 2 * OP_W;
    localparam int CNT_W  = $clog2(OP_W);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OP_W - 1);

    localparam logic [7:0] UIO_OE_MASK = 8'b1000_0000;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    function automatic logic [PROD_W-1:0] widen_operand(input logic [OP_W-1:0] op);
        return {{(PROD_W-OP_W){1'b0}}, op};
    endfunction

endpackage

// File: rtl/mult4x4_datapath.sv
// rtl/mult4x4_datapath.sv - shift-add accumulator, multiplicand and multiplier registers
module mult4x4_datapath
    import mult4x4_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic [PROD_W-1:0] acc_next
);

    logic [PROD_W-1:0] acc;
    logic [PROD_W-1:0] mcand;
    logic [OP_W-1:0]   mplier;

    // Exposed combinationally so the top can capture the final sum on the last step edge.
    assign acc_next = mplier[0] ? (acc + mcand) : acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (load) begin
            acc    <= '0;
            mcand  <= widen_operand(a);
            mplier <= b;
        end else if (step) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

endmodule

// File: rtl/tt_um_mult_4x4.sv
// rtl/tt_um_mult_4x4.sv - TinyTapeout tile: sequential unsigned 4x4 shift-add multiplier
module tt_um_mult_4x4
    import mult4x4_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              start_q;
    logic              done_q;
    logic [PROD_W-1:0] prod_q;
    logic [PROD_W-1:0] acc_next;
    logic              launch;
    logic              dp_load;
    logic              dp_step;
    logic              unused_ok;

    assign unused_ok = &{1'b0, uio_in[7:1]};

    // Rising-edge detect so a held start launches only once.
    assign launch  = uio_in[0] & ~start_q;
    assign dp_load = ena && (state == IDLE) && launch;
    assign dp_step = ena && (state == CALC);

    mult4x4_datapath u_datapath (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (dp_load),
        .step     (dp_step),
        .a        (ui_in[7:4]),
        .b        (ui_in[3:0]),
        .acc_next (acc_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            prod_q  <= '0;
        end else if (ena) begin
            start_q <= uio_in[0];
            case (state)
                IDLE: begin
                    if (launch) begin
                        cnt    <= '0;
                        done_q <= 1'b0;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    if (cnt == CNT_LAST) begin
                        prod_q <= acc_next;
                        done_q <= 1'b1;
                        cnt    <= '0;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign uo_out  = prod_q;
    assign uio_out = {done_q, 7'b000_0000};
    assign uio_oe  = UIO_OE_MASK;

endmodule

// File: tb/tb_tt_um_mult_4x4.sv
// tb/tb_tt_um_mult_4x4.sv - randomized self-checking bench for tt_um_mult_4x4
module tb_tt_um_mult_4x4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    wire  [7:0] uo_out;
    wire  [7:0] uio_out;
    wire  [7:0] uio_oe;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] model_prod = 8'h00;

    always #5 clk = ~clk;

    tt_um_mult_4x4 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start low for one edge, then rising start with operands; returns just after the launch edge.
    task automatic launch(input logic [3:0] a, input logic [3:0] b);
        uio_in = {7'($urandom), 1'b0};
        tick();
        ui_in     = {a, b};
        uio_in[0] = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        vectors++;
        if (uo_out !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_uo_out: got %02h expected 00", uo_out);
        end
        vectors++;
        if (uio_out !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_uio_out: got %02h expected 00", uio_out);
        end
        vectors++;
        if (uio_oe !== 8'h80) begin
            miscompares++;
            $display("FAIL reset_uio_oe: got %02h expected 80", uio_oe);
        end
        tick();
        tick();
        rst_n = 1'b1;
        model_prod = 8'h00;
        tick();
    endtask

    task automatic test_directed();
        logic [3:0] ta [4] = '{4'd3, 4'd15, 4'd0, 4'd1};
        logic [3:0] tb [4] = '{4'd5, 4'd15, 4'd9, 4'd1};
        for (int i = 0; i < 4; i++) begin
            launch(ta[i], tb[i]);
            for (int k = 1; k <= 3; k++) begin
                tick();
                vectors++;
                if (uio_out[7] !== 1'b0 || uo_out !== model_prod) begin
                    miscompares++;
                    $display("FAIL directed_busy[%0d] edge+%0d: done=%b uo=%0d expected done=0 uo=%0d",
                             i, k, uio_out[7], uo_out, model_prod);
                end
            end
            tick();
            model_prod = 8'(ta[i] * tb[i]);
            vectors++;
            if (uio_out !== 8'h80 || uo_out !== model_prod) begin
                miscompares++;
                $display("FAIL directed_done[%0d] %0d*%0d: uio_out=%02h uo=%0d expected uio_out=80 uo=%0d",
                         i, ta[i], tb[i], uio_out, uo_out, model_prod);
            end
            uio_in[0] = 1'b0;
        end
    endtask

    task automatic test_exhaustive();
        int off = int'($urandom_range(255));
        for (int i = 0; i < 256; i++) begin
            int idx = (i + off) % 256;
            logic [3:0] a = 4'(idx >> 4);
            logic [3:0] b = 4'(idx);
            launch(a, b);
            ui_in = 8'($urandom);
            repeat (3) tick();
            tick();
            model_prod = 8'(a * b);
            vectors++;
            if (uio_out[7] !== 1'b1 || uo_out !== model_prod) begin
                miscompares++;
                $display("FAIL exhaustive %0d*%0d: done=%b uo=%0d expected done=1 uo=%0d",
                         a, b, uio_out[7], uo_out, model_prod);
            end
            uio_in[0] = 1'b0;
        end
    endtask

    task automatic test_held_start();
        logic [3:0] a = 4'($urandom_range(1, 15));
        logic [3:0] b = 4'($urandom_range(1, 15));
        launch(a, b);
        repeat (4) tick();
        model_prod = 8'(a * b);
        for (int k = 0; k < 10; k++) begin
            ui_in = 8'($urandom);
            tick();
            vectors++;
            if (uio_out[7] !== 1'b1 || uo_out !== model_prod) begin
                miscompares++;
                $display("FAIL held_start cycle %0d: done=%b uo=%0d expected done=1 uo=%0d",
                         k, uio_out[7], uo_out, model_prod);
            end
        end
        uio_in[0] = 1'b0;
    endtask

    task automatic test_change_during_calc();
        for (int r = 0; r < 6; r++) begin
            logic [3:0] a = 4'($urandom);
            logic [3:0] b = 4'($urandom);
            launch(a, b);
            ui_in = 8'($urandom);
            tick();
            uio_in[0] = 1'b0;
            ui_in = 8'($urandom);
            tick();
            uio_in[0] = 1'b1;
            ui_in = 8'($urandom);
            tick();
            tick();
            model_prod = 8'(a * b);
            vectors++;
            if (uio_out[7] !== 1'b1 || uo_out !== model_prod) begin
                miscompares++;
                $display("FAIL change_during_calc %0d*%0d: done=%b uo=%0d expected done=1 uo=%0d",
                         a, b, uio_out[7], uo_out, model_prod);
            end
            tick();
            vectors++;
            if (uio_out[7] !== 1'b1 || uo_out !== model_prod) begin
                miscompares++;
                $display("FAIL no_latched_relaunch: done=%b uo=%0d expected done=1 uo=%0d",
                         uio_out[7], uo_out, model_prod);
            end
            uio_in[0] = 1'b0;
        end
    endtask

    task automatic test_reset_mid_calc();
        launch(4'd13, 4'd11);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        vectors++;
        if (uo_out !== 8'h00 || uio_out !== 8'h00 || uio_oe !== 8'h80) begin
            miscompares++;
            $display("FAIL reset_mid_calc: uo=%02h uio_out=%02h uio_oe=%02h expected 00 00 80",
                     uo_out, uio_out, uio_oe);
        end
        uio_in = 8'h00;
        model_prod = 8'h00;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            vectors++;
            if (uio_out !== 8'h00 || uo_out !== 8'h00 || uio_oe !== 8'h80) begin
                miscompares++;
                $display("FAIL after_abort cycle %0d: uio_out=%02h uo=%02h uio_oe=%02h expected 00 00 80",
                         k, uio_out, uo_out, uio_oe);
            end
        end
    endtask

    task automatic test_ena_stall();
        logic [3:0] a = 4'($urandom_range(2, 15));
        logic [3:0] b = 4'($urandom_range(2, 15));
        launch(a, b);
        tick();
        ena = 1'b0;
        for (int k = 0; k < 3; k++) begin
            uio_in[0] = k[0];
            tick();
        end
        uio_in[0] = 1'b1;
        ena = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            vectors++;
            if (uio_out[7] !== 1'b0 || uo_out !== model_prod) begin
                miscompares++;
                $display("FAIL ena_stall_early %0d: done=%b uo=%0d expected done=0 uo=%0d",
                         k, uio_out[7], uo_out, model_prod);
            end
        end
        tick();
        model_prod = 8'(a * b);
        vectors++;
        if (uio_out[7] !== 1'b1 || uo_out !== model_prod) begin
            miscompares++;
            $display("FAIL ena_stall_done %0d*%0d: done=%b uo=%0d expected done=1 uo=%0d",
                     a, b, uio_out[7], uo_out, model_prod);
        end
        uio_in[0] = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 20; r++) begin
            logic [3:0] a = 4'($urandom);
            logic [3:0] b = 4'($urandom);
            launch(a, b);
            repeat (4) tick();
            model_prod = 8'(a * b);
            vectors++;
            if (uio_out !== 8'h80 || uo_out !== model_prod) begin
                miscompares++;
                $display("FAIL back_to_back %0d*%0d: uio_out=%02h uo=%0d expected uio_out=80 uo=%0d",
                         a, b, uio_out, uo_out, model_prod);
            end
            uio_in[0] = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_exhaustive();
        test_held_start();
        test_change_during_calc();
        test_reset_mid_calc();
        test_ena_stall();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
